// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: per-port register offsets and the
// addresses of the global pin-change registers.
package gpio_bank_pkg;

  localparam logic [1:0] OFF_DDR   = 2'd0;
  localparam logic [1:0] OFF_PORT  = 2'd1;
  localparam logic [1:0] OFF_PIN   = 2'd2;
  localparam logic [1:0] OFF_PCMSK = 2'd3;

  // The global registers sit directly after the last port's register block.
  function automatic int pcifr_addr(input int num_ports);
    return 4 * num_ports;
  endfunction

  function automatic int pcicr_addr(input int num_ports);
    return 4 * num_ports + 1;
  endfunction

endpackage

// File: rtl/gpio_port_slice.sv
// One GPIO port: DDR/PORT/PCMSK registers, 2-flop pin synchroniser and the
// masked pin-change detector that feeds the bank's PCIFR bit for this port.
module gpio_port_slice
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             wr_en,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] ddr,
  output logic [WIDTH-1:0] port,
  output logic [WIDTH-1:0] pcmsk,
  output logic [WIDTH-1:0] pin_sync,
  output logic             change
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  // NOTE: non-blocking assignments keep the synchroniser chain a true
  // two-stage shift; blocking ones would collapse it into a single flop.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ddr   <= '0;
      port  <= '0;
      pcmsk <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (wr_en) begin
        case (offset)
          OFF_DDR:   ddr   <= wr_data;
          OFF_PORT:  port  <= wr_data;
          OFF_PIN:   port  <= port ^ wr_data;
          OFF_PCMSK: pcmsk <= wr_data;
          default:   ;
        endcase
      end
    end
  end

  assign pin_sync = sync2;
  assign change   = |((sync2 ^ prev) & pcmsk);

endmodule

// File: rtl/gpio_bank.sv
// NUM_PORTS AVR-style GPIO ports behind a small register bus, with
// pin-change interrupt flags (PCIFR), enables (PCICR) and a combined irq.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 5
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  input  logic [NUM_PORTS*WIDTH-1:0] pin_in,
  output logic [NUM_PORTS*WIDTH-1:0] port_out,
  output logic [NUM_PORTS*WIDTH-1:0] ddr_out,
  output logic [NUM_PORTS*WIDTH-1:0] pullup_out,
  output logic                       irq
);

  localparam logic [ADDR_W-1:0] PCIFR_A = ADDR_W'(pcifr_addr(NUM_PORTS));
  localparam logic [ADDR_W-1:0] PCICR_A = ADDR_W'(pcicr_addr(NUM_PORTS));

  logic [NUM_PORTS-1:0]       port_hit;
  logic [NUM_PORTS-1:0]       change;
  logic [NUM_PORTS*WIDTH-1:0] pcmsk_all;
  logic [NUM_PORTS*WIDTH-1:0] pin_sync_all;
  logic [NUM_PORTS-1:0]       pcifr;
  logic [NUM_PORTS-1:0]       pcicr;
  logic [NUM_PORTS-1:0]       pcifr_clr;
  logic [WIDTH-1:0]           rd_next;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    // Upper address bits select the port block; p < NUM_PORTS keeps the
    // global registers out of every port's decode.
    assign port_hit[p] = (addr[ADDR_W-1:2] == (ADDR_W-2)'(p));

    gpio_port_slice #(
      .WIDTH (WIDTH)
    ) u_slice (
      .clk      (clk),
      .clr_n    (clr_n),
      .pin_in   (pin_in[p*WIDTH +: WIDTH]),
      .wr_en    (wr_en & port_hit[p]),
      .offset   (addr[1:0]),
      .wr_data  (wr_data),
      .ddr      (ddr_out[p*WIDTH +: WIDTH]),
      .port     (port_out[p*WIDTH +: WIDTH]),
      .pcmsk    (pcmsk_all[p*WIDTH +: WIDTH]),
      .pin_sync (pin_sync_all[p*WIDTH +: WIDTH]),
      .change   (change[p])
    );
  end

  assign pullup_out = ~ddr_out & port_out;
  assign pcifr_clr  = (wr_en && addr == PCIFR_A) ? wr_data[NUM_PORTS-1:0] : '0;

  // A change arriving in the same cycle as its write-1-to-clear keeps the flag set.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pcifr <= '0;
      pcicr <= '0;
    end else begin
      pcifr <= (pcifr & ~pcifr_clr) | change;
      if (wr_en && addr == PCICR_A) pcicr <= wr_data[NUM_PORTS-1:0];
    end
  end

  assign irq = |(pcifr & pcicr);

  // NOTE: rd_next gets a default before any branch so the mux cannot infer a latch.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p]) begin
        case (addr[1:0])
          OFF_DDR:   rd_next = ddr_out[p*WIDTH +: WIDTH];
          OFF_PORT:  rd_next = port_out[p*WIDTH +: WIDTH];
          OFF_PIN:   rd_next = pin_sync_all[p*WIDTH +: WIDTH];
          OFF_PCMSK: rd_next = pcmsk_all[p*WIDTH +: WIDTH];
          default:   rd_next = '0;
        endcase
      end
    end
    if (addr == PCIFR_A) rd_next = WIDTH'(pcifr);
    if (addr == PCICR_A) rd_next = WIDTH'(pcicr);
  end

  // Sampling before any same-cycle write lands gives read-before-write order.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) rd_data <= '0;
    else if (rd_en) rd_data <= rd_next;
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: register reads go through a queue of
// expected values, pin outputs and irq are compared directly.
module tb_gpio_bank;

  localparam int WIDTH = 8;
  localparam int NP    = 4;
  localparam int AW    = 5;
  localparam int NW    = NP * WIDTH;

  localparam logic [AW-1:0] A_PCIFR = AW'(4 * NP);
  localparam logic [AW-1:0] A_PCICR = AW'(4 * NP + 1);
  localparam logic [AW-1:0] A_UNMAP = AW'(4 * NP + 2);

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [WIDTH-1:0] rd_data;
  logic [NW-1:0]    pin_in = '1;
  logic [NW-1:0]    port_out;
  logic [NW-1:0]    ddr_out;
  logic [NW-1:0]    pullup_out;
  logic             irq;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  gpio_bank #(
    .WIDTH     (WIDTH),
    .NUM_PORTS (NP),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .addr       (addr),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .pin_in     (pin_in),
    .port_out   (port_out),
    .ddr_out    (ddr_out),
    .pullup_out (pullup_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Issues one read, queues its expectation and scores it once rd_data updates.
  task automatic bus_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp,
                          input string name);
    logic [WIDTH-1:0] e;
    addr  = a;
    rd_en = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    rd_en = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (rd_data !== e) begin
      $display("FAIL %s: rd_data got %h expected %h", name, rd_data, e);
      miscompares++;
    end
  endtask

  task automatic test_reset;
    pin_in = '1;
    clr_n  = 1'b0;
    idle(2);
    vectors++;
    if ({port_out, ddr_out, pullup_out} !== '0 || irq !== 1'b0 || rd_data !== '0) begin
      $display("FAIL reset_outputs: port %h ddr %h pullup %h irq %b rd %h expected all 0",
               port_out, ddr_out, pullup_out, irq, rd_data);
      miscompares++;
    end
    clr_n = 1'b1;
    idle(5);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL reset_irq: irq got %b expected 0", irq);
      miscompares++;
    end
    bus_read(A_PCIFR, 8'h00, "reset_pcifr");
    bus_read(5'd2, 8'hFF, "reset_pin0");
    bus_read(5'd14, 8'hFF, "reset_pin3");
  endtask

  task automatic test_ddr_port;
    bus_write(5'd4, 8'hF0);
    bus_write(5'd5, 8'h5A);
    vectors++;
    if (ddr_out[15:8] !== 8'hF0 || port_out[15:8] !== 8'h5A || pullup_out[15:8] !== 8'h0A) begin
      $display("FAIL ddr_port1: ddr %h port %h pullup %h expected f0 5a 0a",
               ddr_out[15:8], port_out[15:8], pullup_out[15:8]);
      miscompares++;
    end
    vectors++;
    if (ddr_out[7:0] !== 8'h00 || port_out[7:0] !== 8'h00) begin
      $display("FAIL ddr_port0_untouched: ddr %h port %h expected 00 00",
               ddr_out[7:0], port_out[7:0]);
      miscompares++;
    end
    bus_read(5'd4, 8'hF0, "read_ddr1");
    bus_read(5'd5, 8'h5A, "read_port1");
  endtask

  task automatic test_pin_toggle;
    bus_write(5'd1, 8'h0F);
    bus_write(5'd2, 8'hFF);
    vectors++;
    if (port_out[7:0] !== 8'hF0) begin
      $display("FAIL pin_toggle: port0 got %h expected f0", port_out[7:0]);
      miscompares++;
    end
    bus_write(5'd2, 8'h00);
    vectors++;
    if (port_out[7:0] !== 8'hF0) begin
      $display("FAIL pin_toggle_zero: port0 got %h expected f0", port_out[7:0]);
      miscompares++;
    end
    bus_read(5'd1, 8'hF0, "read_port0_after_toggle");
  endtask

  task automatic test_pcint;
    pin_in = '0;
    idle(4);
    bus_write(5'd11, 8'h01);
    bus_write(A_PCICR, 8'h04);
    bus_read(A_PCIFR, 8'h00, "pcifr_quiet");
    pin_in[16] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL pcint_early: irq got %b expected 0 after one sync edge", irq);
      miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (irq !== 1'b1) begin
      $display("FAIL pcint_irq: irq got %b expected 1 two edges after sampling", irq);
      miscompares++;
    end
    bus_read(A_PCIFR, 8'h04, "pcint_pcifr");
    bus_read(5'd10, 8'h01, "pcint_pin2");
    bus_write(A_PCIFR, 8'h04);
    pin_in[17] = 1'b1;
    idle(4);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL pcint_masked: irq got %b expected 0", irq);
      miscompares++;
    end
    bus_read(A_PCIFR, 8'h00, "pcint_masked_pcifr");
    bus_read(5'd10, 8'h03, "pcint_masked_pin2");
  endtask

  task automatic test_set_clear;
    pin_in[16] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_write(A_PCIFR, 8'h04);
    vectors++;
    if (irq !== 1'b1) begin
      $display("FAIL set_wins_irq: irq got %b expected 1", irq);
      miscompares++;
    end
    bus_read(A_PCIFR, 8'h04, "set_wins_pcifr");
    bus_write(A_PCIFR, 8'h04);
    vectors++;
    if (irq !== 1'b0) begin
      $display("FAIL w1c_irq: irq got %b expected 0", irq);
      miscompares++;
    end
    bus_read(A_PCIFR, 8'h00, "w1c_pcifr");
  endtask

  task automatic test_unmapped;
    bus_write(A_UNMAP, 8'hFF);
    bus_read(A_UNMAP, 8'h00, "unmapped_read");
    bus_read(5'd31, 8'h00, "unmapped_top");
    bus_write(A_PCICR, 8'hFF);
    bus_read(A_PCICR, 8'h0F, "pcicr_upper_bits");
    bus_write(A_PCICR, 8'h04);
    bus_read(5'd4, 8'hF0, "ddr1_after_unmapped_write");
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] e;
    addr    = 5'd4;
    wr_data = 8'h3C;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    exp_q.push_back(8'hF0);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    e = exp_q.pop_front();
    vectors++;
    if (rd_data !== e) begin
      $display("FAIL read_before_write: rd_data got %h expected %h", rd_data, e);
      miscompares++;
    end
    bus_read(5'd4, 8'h3C, "b2b_ddr1");
    bus_read(5'd5, 8'h5A, "b2b_port1");
    bus_read(5'd1, 8'hF0, "b2b_port0");
    bus_read(5'd11, 8'h01, "b2b_pcmsk2");
    bus_read(A_PCICR, 8'h04, "b2b_pcicr");
    bus_read(5'd4, 8'h3C, "b2b_ddr1_again");
  endtask

  task automatic test_async_reset;
    addr    = 5'd5;
    wr_data = 8'hAA;
    wr_en   = 1'b1;
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    vectors++;
    if ({port_out, ddr_out, pullup_out} !== '0 || irq !== 1'b0 || rd_data !== '0) begin
      $display("FAIL async_reset: port %h ddr %h pullup %h irq %b rd %h expected all 0",
               port_out, ddr_out, pullup_out, irq, rd_data);
      miscompares++;
    end
    wr_en = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    idle(3);
    bus_read(5'd11, 8'h00, "pcmsk2_after_async_reset");
    bus_read(A_PCICR, 8'h00, "pcicr_after_async_reset");
  endtask

  initial begin
    test_reset();
    test_ddr_port();
    test_pin_toggle();
    test_pcint();
    test_set_clear();
    test_unmapped();
    test_back_to_back();
    test_async_reset();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised successor to the single-pair GPIO block. It implements NUM_PORTS AVR-style ports of WIDTH bits each, with DDR, PORT, PIN and PCMSK registers per port.
- Adds a 2-flop input synchroniser, toggle-on-PIN-write, pull-up indication and pin-change interrupt flags and enables.
- Sits between the CPU I/O register bus and the external pins; irq feeds the interrupt controller.

Parameters:
- WIDTH, 8, bits per port.
- NUM_PORTS, 4, number of ports. Must satisfy 1 <= NUM_PORTS <= WIDTH.
- ADDR_W, 5, register address width. Must satisfy 2^ADDR_W >= 4*NUM_PORTS+2.

Ports:
- clk  input  1  system clock, rising edge
- clr_n  input  1  asynchronous active-low reset
- addr  input  ADDR_W  register address
- wr_en  input  1  write strobe, one cycle
- rd_en  input  1  read strobe, one cycle
- wr_data  input  WIDTH  write data
- rd_data  output  WIDTH  registered read data
- pin_in  input  NUM_PORTS*WIDTH  raw asynchronous pin levels; port p occupies bits [p*WIDTH +: WIDTH]
- port_out  output  NUM_PORTS*WIDTH  PORT registers
- ddr_out  output  NUM_PORTS*WIDTH  DDR registers (1 = output)
- pullup_out  output  NUM_PORTS*WIDTH  ~DDR & PORT, per bit
- irq  output  1  pin-change interrupt request

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (clr_n).
- Reset clears every register, synchroniser flop, previous-sample register and rd_data, so all outputs are 0.
- Register map for port p, base 4p:
  - +0 DDR: read/write.
  - +1 PORT: read/write.
  - +2 PIN: reads the synchronised pins. A write XORs wr_data into PORT; PIN itself is not writable.
  - +3 PCMSK: read/write.
- Global registers:
  - 4*NUM_PORTS = PCIFR: bit p is port p's flag. Write-1-to-clear. Bits >= NUM_PORTS read 0.
  - 4*NUM_PORTS+1 = PCICR: bit p enables port p. Bits >= NUM_PORTS are not stored and read 0.
- Unmapped addresses: writes are ignored, reads return 0.
- Writes take effect at the clk edge where wr_en=1.
- Reads: rd_data is updated at the edge where rd_en=1 and holds its value otherwise. Latency is 1 cycle.
- Simultaneous wr_en and rd_en to the same address: the read returns the pre-write value.
- Synchroniser: sync1 <= pin_in; sync2 <= sync1. PIN reads sync2.
- Latency: a pin_in change before edge t is visible in PIN after edge t+1.
- Pin-change detection: prev <= sync2 every cycle. change_p = (sync2_p ^ prev_p) & PCMSK_p. PCIFR[p] sets at the edge where |change_p is true.
- Timing: a pin edge sampled at edge t sets its flag at edge t+2 and asserts irq after edge t+2.
- Set and clear in the same cycle on the same PCIFR bit: set wins, and the flag stays 1.
- irq = |(PCIFR & PCICR), combinational from registers. It is glitch-free because it depends only on flops.
- PCMSK=0 suppresses flag setting only; PIN still tracks the pins.
- Because PCMSK resets to 0, the post-reset synchroniser fill never raises a flag.
- Toggle write on PIN and a write to PORT cannot coincide (single address bus). A PIN toggle with wr_data=0 leaves PORT unchanged.
- clr_n asserted mid-operation clears state immediately and asynchronously. In-flight flags are lost.

Decomposition:
- Shared package: register offset constants (OFF_DDR=0, OFF_PORT=1, OFF_PIN=2, OFF_PCMSK=3) and the PCIFR/PCICR address functions of NUM_PORTS.
- One sub-module, gpio_port_slice: holds one port's DDR/PORT/PCMSK, synchroniser, prev register and change output. It is generated NUM_PORTS times.
- The top level handles address decode, the read mux, PCIFR/PCICR and irq.

Test Plan:
- Reset with pin_in=all 1s, PCMSK=0 -> after 5 cycles: PCIFR=0, irq=0, and a read of PIN0 returns 0xFF.
- Write DDR1=0xF0, PORT1=0x5A -> ddr_out[15:8]=0xF0, port_out[15:8]=0x5A, pullup_out[15:8]=0x0A.
- PORT0=0x0F, then write 0xFF to PIN0 -> port_out[7:0]=0xF0. Write 0x00 to PIN0 -> still 0xF0.
- PCMSK2=0x01, PCICR=0x04, toggle pin_in[16] 0->1 -> PCIFR=0x04 and irq=1 two edges after sampling; pin_in[17] toggle alone produces no flag.
- Flag set and W1C to PCIFR=0x04 in the same cycle -> PCIFR stays 0x04. A W1C on a quiet cycle -> PCIFR=0x00, irq=0.
- Read of address 4*NUM_PORTS+2 -> rd_data=0 one cycle later. Assert clr_n=0 mid-burst -> all outputs 0 immediately.
